// File: rtl/sprite_reg_writer_if.sv
// Write/burst request bus into the sprite channel register bank.
// The master offers beats and burst requests; the slave returns wr_ready.
interface sprite_reg_writer_if;
   logic        wr_valid;
   logic        wr_ready;
   logic [3:0]  wr_addr;
   logic [31:0] wr_data;
   logic        burst_start;
   logic [3:0]  burst_base;
   logic [3:0]  burst_cnt;

   modport master (
      output wr_valid, wr_addr, wr_data, burst_start, burst_base, burst_cnt,
      input  wr_ready
   );

   modport slave (
      input  wr_valid, wr_addr, wr_data, burst_start, burst_base, burst_cnt,
      output wr_ready
   );
endinterface

// File: rtl/sprite_reg_writer.sv
// Sixteen 32-bit sprite channel registers, written singly or by an
// auto-incrementing burst that wraps modulo 16.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | single writes accepted; burst_start launches a burst
//   BURST | each accepted beat writes channel at ptr, ptr++, beats--
//   DONE  | one-cycle burst_done pulse, no beats accepted
module sprite_reg_writer (
   input  logic                  clk,
   input  logic                  reset_n,
   sprite_reg_writer_if.slave    bus,
   input  logic                  clear_all,
   output logic [511:0]          channels,
   output logic [15:0]           written,
   output logic [15:0]           last_sel,
   output logic                  busy,
   output logic                  burst_done
);

   typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

   state_t      state;
   logic [3:0]  ptr;
   logic [3:0]  beats;
   logic        accept;
   logic [3:0]  wa;

   // burst_start in IDLE steals the cycle, so a coincident beat is refused
   assign bus.wr_ready = !clear_all &&
                         ((state == BURST) || ((state == IDLE) && !bus.burst_start));
   assign accept       = bus.wr_valid && bus.wr_ready;
   assign wa           = (state == BURST) ? ptr : bus.wr_addr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         ptr        <= 4'd0;
         beats      <= 4'd0;
         channels   <= '0;
         written    <= '0;
         last_sel   <= '0;
         busy       <= 1'b0;
         burst_done <= 1'b0;
      end else if (clear_all) begin
         state      <= IDLE;
         ptr        <= 4'd0;
         beats      <= 4'd0;
         channels   <= '0;
         written    <= '0;
         last_sel   <= '0;
         busy       <= 1'b0;
         burst_done <= 1'b0;
      end else begin
         if (accept) begin
            channels[{wa, 5'd0} +: 32] <= bus.wr_data;
            written[wa]                <= 1'b1;
            last_sel                   <= 16'd1 << wa;
         end
         case (state)
            IDLE: begin
               if (bus.burst_start) begin
                  state <= BURST;
                  ptr   <= bus.burst_base;
                  beats <= bus.burst_cnt;
                  busy  <= 1'b1;
               end
            end
            BURST: begin
               if (accept) begin
                  ptr <= ptr + 4'd1;
                  if (beats == 4'd0) begin
                     state      <= DONE;
                     burst_done <= 1'b1;
                  end else begin
                     beats <= beats - 4'd1;
                  end
               end
            end
            DONE: begin
               state      <= IDLE;
               busy       <= 1'b0;
               burst_done <= 1'b0;
            end
            default: begin
               state      <= IDLE;
               busy       <= 1'b0;
               burst_done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sprite_reg_writer.sv
// Bench for sprite_reg_writer: directed vector table, abort/reset sequences,
// and random traffic checked against a queue-based burst model.
module tb_sprite_reg_writer;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          clear_all = 1'b0;
   logic [511:0]  channels;
   logic [15:0]   written;
   logic [15:0]   last_sel;
   logic          busy;
   logic          burst_done;

   sprite_reg_writer_if bus();

   sprite_reg_writer dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .bus        (bus),
      .clear_all  (clear_all),
      .channels   (channels),
      .written    (written),
      .last_sel   (last_sel),
      .busy       (busy),
      .burst_done (burst_done)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   logic last_rdy;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: a burst is a queue of target channels computed up front
   logic [31:0] m_ch [16];
   logic [15:0] m_wr;
   logic [15:0] m_last;
   bit          m_in_burst;
   bit          m_done;
   int          q [$];

   function automatic void model_reset();
      for (int i = 0; i < 16; i++) m_ch[i] = '0;
      m_wr = '0;
      m_last = '0;
      q.delete();
      m_in_burst = 0;
      m_done = 0;
   endfunction

   function automatic bit model_ready();
      if (clear_all) return 0;
      if (m_done) return 0;
      if (m_in_burst) return 1;
      return !bus.burst_start;
   endfunction

   function automatic void model_write(input int a, input logic [31:0] d);
      m_ch[a] = d;
      m_wr[a] = 1'b1;
      m_last = '0;
      m_last[a] = 1'b1;
   endfunction

   function automatic void model_step();
      int a;
      if (clear_all) begin
         model_reset();
         return;
      end
      if (m_done) begin
         m_done = 0;
         return;
      end
      if (m_in_burst) begin
         if (bus.wr_valid) begin
            a = q.pop_front();
            model_write(a, bus.wr_data);
            if (q.size() == 0) begin
               m_in_burst = 0;
               m_done = 1;
            end
         end
      end else if (bus.burst_start) begin
         m_in_burst = 1;
         for (int k = 0; k <= int'(bus.burst_cnt); k++)
            q.push_back((int'(bus.burst_base) + k) % 16);
      end else if (bus.wr_valid) begin
         model_write(int'(bus.wr_addr), bus.wr_data);
      end
   endfunction

   function automatic logic [511:0] model_bank();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = m_ch[i];
      return r;
   endfunction

   task automatic drive(input logic v, input logic [3:0] a, input logic [31:0] d,
                        input logic bs, input logic [3:0] base, input logic [3:0] cnt,
                        input logic clr);
      bus.wr_valid    = v;
      bus.wr_addr     = a;
      bus.wr_data     = d;
      bus.burst_start = bs;
      bus.burst_base  = base;
      bus.burst_cnt   = cnt;
      clear_all       = clr;
   endtask

   task automatic cycle();
      @(negedge clk);
      last_rdy = bus.wr_ready;
      chk("wr_ready", last_rdy, model_ready());
      @(posedge clk);
      model_step();
      #1;
      chk("channels", channels, model_bank());
      chk("written", written, m_wr);
      chk("last_sel", last_sel, m_last);
      chk("busy", busy, m_in_burst || m_done);
      chk("burst_done", burst_done, m_done);
   endtask

   typedef struct {
      logic        v;
      logic [3:0]  a;
      logic [31:0] d;
      logic        bs;
      logic [3:0]  base;
      logic [3:0]  cnt;
      logic        clr;
      logic        e_rdy;
      logic        e_busy;
      logic        e_done;
      logic [15:0] e_wr;
      logic [15:0] e_last;
      int          ch;
      logic [31:0] e_chv;
   } vec_t;

   vec_t tbl [17];

   function automatic vec_t mk(input logic v, input logic [3:0] a, input logic [31:0] d,
                               input logic bs, input logic [3:0] base, input logic [3:0] cnt,
                               input logic clr, input logic e_rdy, input logic e_busy,
                               input logic e_done, input logic [15:0] e_wr,
                               input logic [15:0] e_last, input int ch, input logic [31:0] e_chv);
      vec_t r;
      r.v = v; r.a = a; r.d = d; r.bs = bs; r.base = base; r.cnt = cnt; r.clr = clr;
      r.e_rdy = e_rdy; r.e_busy = e_busy; r.e_done = e_done;
      r.e_wr = e_wr; r.e_last = e_last; r.ch = ch; r.e_chv = e_chv;
      return r;
   endfunction

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0);
      model_reset();
      #2;
      chk("reset channels", channels, '0);
      chk("reset written", written, '0);
      chk("reset last_sel", last_sel, '0);
      chk("reset busy", busy, 1'b0);
      chk("reset burst_done", burst_done, 1'b0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      //           v a  data          bs b  c  clr rdy busy done written  last     ch value
      tbl[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 0,  1,  0,   0,  16'h0020, 16'h0020, 5, 32'hDEADBEEF);
      tbl[1]  = mk(1, 2, 32'h00000BAD, 1, 14, 3, 0, 0,  1,   0,  16'h0020, 16'h0020, 2, 32'h0);
      tbl[2]  = mk(1, 7, 32'h11,       0, 0, 0, 0,  1,  1,   0,  16'h4020, 16'h4000, 14, 32'h11);
      tbl[3]  = mk(1, 7, 32'h22,       0, 0, 0, 0,  1,  1,   0,  16'hC020, 16'h8000, 15, 32'h22);
      tbl[4]  = mk(1, 7, 32'h33,       0, 0, 0, 0,  1,  1,   0,  16'hC021, 16'h0001, 0, 32'h33);
      tbl[5]  = mk(1, 7, 32'h44,       0, 0, 0, 0,  1,  1,   1,  16'hC023, 16'h0002, 1, 32'h44);
      tbl[6]  = mk(1, 9, 32'h99,       1, 4, 2, 0,  0,  0,   0,  16'hC023, 16'h0002, 9, 32'h0);
      tbl[7]  = mk(0, 0, 32'h0,        0, 0, 0, 0,  1,  0,   0,  16'hC023, 16'h0002, 5, 32'hDEADBEEF);
      tbl[8]  = mk(0, 0, 32'h0,        1, 3, 1, 0,  0,  1,   0,  16'hC023, 16'h0002, 3, 32'h0);
      tbl[9]  = mk(1, 0, 32'hA1,       0, 0, 0, 0,  1,  1,   0,  16'hC02B, 16'h0008, 3, 32'hA1);
      tbl[10] = mk(0, 0, 32'h0,        0, 0, 0, 0,  1,  1,   0,  16'hC02B, 16'h0008, 4, 32'h0);
      tbl[11] = mk(0, 0, 32'h0,        0, 0, 0, 0,  1,  1,   0,  16'hC02B, 16'h0008, 4, 32'h0);
      tbl[12] = mk(0, 0, 32'h0,        0, 0, 0, 0,  1,  1,   0,  16'hC02B, 16'h0008, 4, 32'h0);
      tbl[13] = mk(1, 0, 32'hA2,       0, 0, 0, 0,  1,  1,   1,  16'hC03B, 16'h0010, 4, 32'hA2);
      tbl[14] = mk(0, 0, 32'h0,        0, 0, 0, 0,  0,  0,   0,  16'hC03B, 16'h0010, 5, 32'hDEADBEEF);
      tbl[15] = mk(1, 6, 32'h66,       0, 0, 0, 1,  0,  0,   0,  16'h0000, 16'h0000, 5, 32'h0);
      tbl[16] = mk(0, 0, 32'h0,        0, 0, 0, 0,  1,  0,   0,  16'h0000, 16'h0000, 6, 32'h0);

      for (int i = 0; i < 17; i++) begin
         drive(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].bs, tbl[i].base, tbl[i].cnt, tbl[i].clr);
         cycle();
         chk($sformatf("vec%0d ready", i), last_rdy, tbl[i].e_rdy);
         chk($sformatf("vec%0d busy", i), busy, tbl[i].e_busy);
         chk($sformatf("vec%0d burst_done", i), burst_done, tbl[i].e_done);
         chk($sformatf("vec%0d written", i), written, tbl[i].e_wr);
         chk($sformatf("vec%0d last_sel", i), last_sel, tbl[i].e_last);
         chk($sformatf("vec%0d channel", i), channels[tbl[i].ch*32 +: 32], tbl[i].e_chv);
      end

      // clear_all on the second beat of a 16-beat burst
      drive(0, 0, 0, 1, 0, 15, 0);
      cycle();
      chk("abort busy", busy, 1'b1);
      drive(1, 0, 32'h1, 0, 0, 0, 0);
      cycle();
      chk("abort beat1", channels[31:0], 32'h1);
      drive(1, 0, 32'h2, 0, 0, 0, 1);
      cycle();
      chk("abort ready", last_rdy, 1'b0);
      chk("abort channels", channels, '0);
      chk("abort written", written, '0);
      chk("abort last_sel", last_sel, '0);
      chk("abort busy off", busy, 1'b0);
      drive(0, 0, 0, 0, 0, 0, 0);
      cycle();
      chk("abort no done", burst_done, 1'b0);

      // async reset between edges mid-burst
      drive(0, 0, 0, 1, 8, 5, 0);
      cycle();
      drive(1, 0, 32'h55, 0, 0, 0, 0);
      cycle();
      chk("pre-reset ch8", channels[8*32 +: 32], 32'h55);
      drive(1, 0, 32'h66, 0, 0, 0, 0);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async channels", channels, '0);
      chk("async written", written, '0);
      chk("async last_sel", last_sel, '0);
      chk("async busy", busy, 1'b0);
      chk("async burst_done", burst_done, 1'b0);
      model_reset();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      drive(1, 10, 32'hCAFEF00D, 0, 0, 0, 0);
      cycle();
      chk("post-reset ch10", channels[10*32 +: 32], 32'hCAFEF00D);
      chk("post-reset written", written, 16'h0400);
      chk("post-reset ch9", channels[9*32 +: 32], 32'h0);

      // random traffic against the model
      for (int n = 0; n < 600; n++) begin
         drive($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)), $urandom,
               $urandom_range(0, 9) == 0, 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), $urandom_range(0, 59) == 0);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sprite_reg_writer.md
SPRITE_REG_WRITER -- requirements
Module: sprite_reg_writer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; clk and reset_n are the only timing/reset inputs.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 wr_valid  input  1  write beat offered.
REQ-005 wr_ready  output  1  beat accepted when wr_valid && wr_ready at a rising edge.
REQ-006 wr_addr  input  4  target channel for single writes; ignored in BURST.
REQ-007 wr_data  input  32  beat payload.
REQ-008 burst_start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-009 burst_base  input  4  first channel of the burst.
REQ-010 burst_cnt  input  4  beats in the burst minus one (0 = 1 beat, 15 = 16 beats).
REQ-011 clear_all  input  1  synchronous clear of all channel storage.
REQ-012 channels  output  512  packed channel bank; channel i occupies bits [32*i+31 : 32*i].
REQ-013 written  output  16  bit i set when channel i has been written since the last clear or reset.
REQ-014 last_sel  output  16  one-hot register of the most recently written channel; all zeros if none.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 burst_done  output  1  one-cycle pulse when a burst finishes.

Function
REQ-017 FSM states SHALL be IDLE, BURST and DONE.
REQ-018 wr_ready SHALL be combinational: 1 in BURST; 1 in IDLE unless burst_start is high that cycle; 0 in DONE; 0 whenever clear_all is high.
REQ-019 In IDLE, an accepted beat SHALL write wr_data into channel wr_addr.
REQ-020 In IDLE with burst_start high, the FSM SHALL go to BURST, load the write pointer with burst_base and the beat counter with burst_cnt; burst_start takes priority over a simultaneous wr_valid, and that beat is not accepted.
REQ-021 In BURST, each accepted beat SHALL write to the channel at the pointer, then increment the pointer modulo 16 (15 wraps to 0).
REQ-022 In BURST, the beat counter SHALL decrement on each accepted beat; the beat accepted with counter 0 moves the FSM to DONE.
REQ-023 DONE SHALL last exactly one cycle with burst_done = 1, then return to IDLE.
REQ-024 burst_start in BURST or DONE SHALL be ignored.
REQ-025 Written data SHALL appear on channels, and written/last_sel SHALL update, on the rising edge that accepts the beat (visible the following cycle); no other channel changes.
REQ-026 A 16-beat burst SHALL write every channel exactly once; a burst starting at base b with count c SHALL write channels b..b+c modulo 16.
REQ-027 clear_all SHALL have priority over all writes: at the next edge it zeroes channels, written and last_sel, and forces the FSM to IDLE, aborting any burst without a burst_done pulse.
REQ-028 wr_valid low in BURST SHALL stall the burst with pointer and counter held, with no timeout.

Reset
REQ-029 While reset_n is low, regardless of clk: FSM = IDLE; channels = 0; written = 0; last_sel = 0; pointer = 0; counter = 0; burst_done = 0; busy = 0.
REQ-030 Reset asserted mid-burst SHALL abort the burst, discarding the beat in flight; after reset release the first rising edge operates from IDLE.

Verification
REQ-031 Single write: IDLE, wr_valid=1, wr_addr=5, wr_data=0xDEADBEEF -> next cycle channels[191:160]=0xDEADBEEF, written=0x0020, last_sel=0x0020, all other channels 0.
REQ-032 Wrapping burst: burst_base=14, burst_cnt=3, beats 0x11,0x22,0x33,0x44 back to back -> channels 14,15,0,1 hold 0x11,0x22,0x33,0x44; burst_done pulses once on the cycle after the 4th beat; busy high from the cycle after burst_start until the cycle after DONE.
REQ-033 Stalled burst: burst_cnt=1 with wr_valid low for 3 cycles between beats -> pointer holds, exactly 2 writes, burst_done fires once.
REQ-034 Priority: burst_start and wr_valid (wr_addr=2) in the same IDLE cycle -> wr_ready=0, channel 2 unchanged, FSM in BURST next cycle.
REQ-035 Abort: clear_all asserted during the 2nd beat of a 16-beat burst -> next cycle all outputs zero, FSM IDLE, no burst_done, 2nd beat not written.
REQ-036 Async reset: reset_n pulsed low between clock edges mid-burst -> outputs zero immediately, without waiting for a clock edge; a single write after release succeeds.
